// File: rtl/rgb15k_timing_gen_if.sv
// Fetch bus between the timing generator and the synchronous scan store.
// The store answers pix_req/pix_x/pix_y with pix_in one clock later.
interface rgb15k_timing_gen_if;
  logic       pix_req;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [8:0] pix_in;

  modport master (
    output pix_req,
    output pix_x,
    output pix_y,
    input  pix_in
  );

  modport slave (
    input  pix_req,
    input  pix_x,
    input  pix_y,
    output pix_in
  );
endinterface

// File: rtl/rgb15k_timing_gen.sv
// 15 kHz RGB line/field timing generator: raster counters, fetch strobe and a
// two-stage registered pipeline producing colour, composite syncs and blanking.
module rgb15k_timing_gen #(
  parameter int unsigned H_TOTAL      = 1024,
  parameter int unsigned H_ACTIVE     = 768,
  parameter int unsigned H_SYNC_START = 832,
  parameter int unsigned H_SYNC_LEN   = 75,
  parameter int unsigned V_TOTAL      = 312,
  parameter int unsigned V_ACTIVE     = 288,
  parameter int unsigned V_SYNC_START = 296,
  parameter int unsigned V_SYNC_LEN   = 3
) (
  input  logic                       clkvideo,
  input  logic                       rst_n,
  input  logic                       vresync,
  rgb15k_timing_gen_if.master        fetch,
  output logic [2:0]                 ro,
  output logic [2:0]                 go,
  output logic [2:0]                 bo,
  output logic                       hsync_ext_n,
  output logic                       vsync_ext_n,
  output logic                       csync_ext_n,
  output logic                       blank,
  output logic                       field_start
);

  if (H_TOTAL < 256 || H_TOTAL > 1024) begin : g_chk_htotal
    $error("H_TOTAL must be within 256..1024");
  end
  if (V_TOTAL < 1 || V_TOTAL > 512) begin : g_chk_vtotal
    $error("V_TOTAL must fit the 9-bit line counter");
  end
  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_chk_hsync
    $error("H_SYNC_START + H_SYNC_LEN exceeds H_TOTAL");
  end
  if (V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_chk_vsync
    $error("V_SYNC_START + V_SYNC_LEN exceeds V_TOTAL");
  end
  if (H_ACTIVE > H_SYNC_START) begin : g_chk_hact
    $error("H_ACTIVE exceeds H_SYNC_START");
  end

  // One spare bit so a sync end of exactly H_TOTAL (1024) still compares correctly.
  localparam logic [10:0] HLast  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HAct   = 11'(H_ACTIVE);
  localparam logic [10:0] HsBeg  = 11'(H_SYNC_START);
  localparam logic [10:0] HsEnd  = 11'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [9:0]  VLast  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VAct   = 10'(V_ACTIVE);
  localparam logic [9:0]  VsBeg  = 10'(V_SYNC_START);
  localparam logic [9:0]  VsEnd  = 10'(V_SYNC_START + V_SYNC_LEN);

  logic [9:0]  hcnt_q;
  logic [8:0]  vcnt_q;
  logic        pend_q;
  logic [10:0] hx;
  logic [9:0]  vx;
  logic        hwrap;
  logic        hs0, vs0, act0, fs0;
  logic        hs_q, vs_q, act_q, fs_q;

  assign hx    = {1'b0, hcnt_q};
  assign vx    = {1'b0, vcnt_q};
  assign hwrap = (hx == HLast);

  assign act0 = (hx < HAct) && (vx < VAct);
  assign hs0  = (hx >= HsBeg) && (hx < HsEnd);
  assign vs0  = (vx >= VsBeg) && (vx < VsEnd);
  assign fs0  = (hcnt_q == 10'd0) && (vcnt_q == 9'd0);

  assign fetch.pix_req = act0;
  assign fetch.pix_x   = hcnt_q;
  assign fetch.pix_y   = vcnt_q;

  // A resync request coinciding with the wrap is honoured at that same wrap.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= 10'd0;
      vcnt_q <= 9'd0;
      pend_q <= 1'b0;
    end else if (hwrap) begin
      hcnt_q <= 10'd0;
      pend_q <= 1'b0;
      if (pend_q || vresync || (vx == VLast)) begin
        vcnt_q <= 9'd0;
      end else begin
        vcnt_q <= vcnt_q + 9'd1;
      end
    end else begin
      hcnt_q <= hcnt_q + 10'd1;
      if (vresync) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Stage 1: aligns the raw terms with pix_in arriving from the store.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      act_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      hs_q  <= hs0;
      vs_q  <= vs0;
      act_q <= act0;
      fs_q  <= fs0;
    end
  end

  // Output stage; syncs reset high so no low glitch can escape during reset.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      ro          <= 3'd0;
      go          <= 3'd0;
      bo          <= 3'd0;
      hsync_ext_n <= 1'b1;
      vsync_ext_n <= 1'b1;
      csync_ext_n <= 1'b1;
      blank       <= 1'b1;
      field_start <= 1'b0;
    end else begin
      ro          <= act_q ? fetch.pix_in[8:6] : 3'd0;
      go          <= act_q ? fetch.pix_in[5:3] : 3'd0;
      bo          <= act_q ? fetch.pix_in[2:0] : 3'd0;
      hsync_ext_n <= ~hs_q;
      vsync_ext_n <= ~vs_q;
      csync_ext_n <= ~(hs_q ^ vs_q);
      blank       <= ~act_q;
      field_start <= fs_q;
    end
  end

endmodule

// File: tb/tb_rgb15k_timing_gen.sv
// Directed bench for rgb15k_timing_gen using a reduced raster so two full
// fields stay short; expected figures below are worked out by hand for it.
module tb_rgb15k_timing_gen;
  localparam int HT  = 256;
  localparam int HA  = 192;
  localparam int HSS = 208;
  localparam int HSL = 19;
  localparam int VT  = 20;
  localparam int VA  = 14;
  localparam int VSS = 16;
  localparam int VSL = 3;

  localparam int EXP_HPER   = 256;
  localparam int EXP_HLOW   = 19;
  localparam int EXP_VPER   = 5120;  // 20 lines of 256 clocks
  localparam int EXP_VLOW   = 768;   // 3 lines of 256 clocks
  localparam int EXP_LINES  = 28;    // 14 visible lines x 2 fields
  localparam int EXP_WHITE  = 192;

  logic       clkvideo = 1'b0;
  logic       rst_n;
  logic       vresync;
  logic [2:0] ro, go, bo;
  logic       hsync_ext_n, vsync_ext_n, csync_ext_n, blank, field_start;
  int         store_mode;
  int         checks = 0;
  int         errors = 0;

  rgb15k_timing_gen_if bus ();

  rgb15k_timing_gen #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut (
    .clkvideo    (clkvideo),
    .rst_n       (rst_n),
    .vresync     (vresync),
    .fetch       (bus),
    .ro          (ro),
    .go          (go),
    .bo          (bo),
    .hsync_ext_n (hsync_ext_n),
    .vsync_ext_n (vsync_ext_n),
    .csync_ext_n (csync_ext_n),
    .blank       (blank),
    .field_start (field_start)
  );

  always #5 clkvideo = ~clkvideo;

  function automatic logic [8:0] pattern(input logic [9:0] x, input logic [8:0] y);
    return {x[2:0] ^ 3'd5, y[2:0] ^ 3'd3, x[5:3] ^ 3'd6};
  endfunction

  // Synchronous store: answers every address one clock later, active or not.
  always @(posedge clkvideo)
    bus.pix_in <= (store_mode == 0) ? 9'h1FF : pattern(bus.pix_x, bus.pix_y);

  task automatic step();
    @(posedge clkvideo);
    #1;
  endtask

  task automatic wait_pos(input int x, input int y, input string tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (int'(bus.pix_x) == x && int'(bus.pix_y) == y) begin
        ok = 1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: position (%0d,%0d) never reached", tag, x, y);
    end
  endtask

  task automatic test_reset();
    store_mode = 1;
    vresync = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(); step(); step();
    checks++;
    if ({ro, go, bo} !== 9'd0 || blank !== 1'b1 || field_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rgb=%h blank=%b fs=%b, want 000 1 0",
               {ro, go, bo}, blank, field_start);
    end
    checks++;
    if ({hsync_ext_n, vsync_ext_n, csync_ext_n} !== 3'b111) begin
      errors++;
      $display("FAIL reset_syncs: h/v/c=%b, want 111", {hsync_ext_n, vsync_ext_n, csync_ext_n});
    end
    checks++;
    if (bus.pix_x !== 10'd0 || bus.pix_y !== 9'd0 || bus.pix_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_counters: x=%0d y=%0d req=%b, want 0 0 1",
               bus.pix_x, bus.pix_y, bus.pix_req);
    end
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (bus.pix_x !== 10'd1 || bus.pix_y !== 9'd0 || field_start !== 1'b0) begin
      errors++;
      $display("FAIL release_edge1: x=%0d y=%0d fs=%b, want 1 0 0",
               bus.pix_x, bus.pix_y, field_start);
    end
    step();
    checks++;
    if (field_start !== 1'b1 || {ro, go, bo} !== 9'b101_011_110 || blank !== 1'b0) begin
      errors++;
      $display("FAIL release_edge2: fs=%b rgb=%b blank=%b, want 1 101011110 0",
               field_start, {ro, go, bo}, blank);
    end
    step();
    checks++;
    if (field_start !== 1'b0 || {ro, go, bo} !== 9'b100_011_110) begin
      errors++;
      $display("FAIL release_edge3: fs=%b rgb=%b, want 0 100011110", field_start, {ro, go, bo});
    end
  endtask

  task automatic test_free_run();
    bit ok;
    int hmin, hmax, lmin, lmax, vper, vlow, last_hf, last_vf, bad, lines, badline, lcnt, ox, oy;
    bit act_e, hs_e, vs_e;
    logic ph;
    logic pv;
    logic [2:0] exp_c;
    store_mode = 0;
    ok = 0;
    for (int i = 0; i < HT * VT + 8; i++) begin
      if (field_start === 1'b1) begin
        ok = 1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL free_run_start: field_start stayed 0, want a pulse");
      return;
    end
    hmin = 1 << 30; hmax = 0; lmin = 1 << 30; lmax = 0;
    vper = -1; vlow = -1; last_hf = -1; last_vf = -1;
    bad = 0; lines = 0; badline = 0; lcnt = 0;
    ph = hsync_ext_n;
    pv = vsync_ext_n;
    for (int k = 0; k < 2 * HT * VT; k++) begin
      ox = k % HT;
      oy = (k / HT) % VT;
      act_e = (ox < HA) && (oy < VA);
      hs_e  = (ox >= HSS) && (ox < HSS + HSL);
      vs_e  = (oy >= VSS) && (oy < VSS + VSL);
      exp_c = act_e ? 3'd7 : 3'd0;
      if (ro !== exp_c || go !== exp_c || bo !== exp_c || blank !== !act_e ||
          hsync_ext_n !== !hs_e || vsync_ext_n !== !vs_e ||
          csync_ext_n !== !(hs_e ^ vs_e) || field_start !== (ox == 0 && oy == 0))
        bad++;
      if (ph === 1'b1 && hsync_ext_n === 1'b0) begin
        if (last_hf >= 0) begin
          hmin = (k - last_hf < hmin) ? k - last_hf : hmin;
          hmax = (k - last_hf > hmax) ? k - last_hf : hmax;
        end
        last_hf = k;
      end
      if (ph === 1'b0 && hsync_ext_n === 1'b1 && last_hf >= 0) begin
        lmin = (k - last_hf < lmin) ? k - last_hf : lmin;
        lmax = (k - last_hf > lmax) ? k - last_hf : lmax;
      end
      if (pv === 1'b1 && vsync_ext_n === 1'b0) begin
        if (last_vf >= 0) vper = k - last_vf;
        last_vf = k;
      end
      if (pv === 1'b0 && vsync_ext_n === 1'b1 && last_vf >= 0 && vlow < 0) vlow = k - last_vf;
      if (ro === 3'd7) lcnt++;
      if (ox == HT - 1) begin
        if (lcnt > 0) begin
          lines++;
          if (lcnt != EXP_WHITE) badline++;
        end
        lcnt = 0;
      end
      ph = hsync_ext_n;
      pv = vsync_ext_n;
      step();
    end
    checks++;
    if (hmin != EXP_HPER || hmax != EXP_HPER) begin
      errors++;
      $display("FAIL hsync_period: min=%0d max=%0d, want %0d", hmin, hmax, EXP_HPER);
    end
    checks++;
    if (lmin != EXP_HLOW || lmax != EXP_HLOW) begin
      errors++;
      $display("FAIL hsync_width: min=%0d max=%0d, want %0d", lmin, lmax, EXP_HLOW);
    end
    checks++;
    if (vper != EXP_VPER) begin
      errors++;
      $display("FAIL vsync_period: got %0d clocks, want %0d", vper, EXP_VPER);
    end
    checks++;
    if (vlow != EXP_VLOW) begin
      errors++;
      $display("FAIL vsync_width: got %0d clocks, want %0d", vlow, EXP_VLOW);
    end
    checks++;
    if (lines != EXP_LINES || badline != 0) begin
      errors++;
      $display("FAIL white_lines: lines=%0d bad=%0d, want %0d 0", lines, badline, EXP_LINES);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL raster_model: %0d cycles differ, want 0", bad);
    end
  endtask

  task automatic test_pix_req_latency();
    bit ok;
    store_mode = 1;
    wait_pos(0, 0, "latency_wait", ok);
    if (!ok) return;
    checks++;
    if (bus.pix_req !== 1'b1 || blank !== 1'b1) begin
      errors++;
      $display("FAIL latency_t0: req=%b blank=%b, want 1 1", bus.pix_req, blank);
    end
    step();
    checks++;
    if ({ro, go, bo} !== 9'd0 || field_start !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: rgb=%b fs=%b, want 0 0", {ro, go, bo}, field_start);
    end
    step();
    checks++;
    if ({ro, go, bo} !== 9'b101_011_110 || field_start !== 1'b1) begin
      errors++;
      $display("FAIL latency_t2: rgb=%b fs=%b, want 101011110 1", {ro, go, bo}, field_start);
    end
  endtask

  task automatic test_vresync();
    bit ok;
    wait_pos(100, 5, "vresync_wait", ok);
    if (!ok) return;
    vresync = 1'b1;
    step();
    vresync = 1'b0;
    for (int i = 0; i < 49; i++) step();
    vresync = 1'b1;   // second pulse in the same line must not act twice
    step();
    vresync = 1'b0;
    checks++;
    if (bus.pix_x !== 10'd151 || bus.pix_y !== 9'd5) begin
      errors++;
      $display("FAIL vresync_hold: x=%0d y=%0d, want 151 5", bus.pix_x, bus.pix_y);
    end
    for (int i = 0; i < HT - 151; i++) step();
    checks++;
    if (bus.pix_x !== 10'd0 || bus.pix_y !== 9'd0) begin
      errors++;
      $display("FAIL vresync_restart: x=%0d y=%0d, want 0 0", bus.pix_x, bus.pix_y);
    end
    step(); step();
    checks++;
    if (field_start !== 1'b1) begin
      errors++;
      $display("FAIL vresync_field_start: got %b, want 1", field_start);
    end
    for (int i = 0; i < HT - 2; i++) step();
    checks++;
    if (bus.pix_x !== 10'd0 || bus.pix_y !== 9'd1) begin
      errors++;
      $display("FAIL vresync_once: x=%0d y=%0d, want 0 1", bus.pix_x, bus.pix_y);
    end
  endtask

  task automatic test_resync_at_wrap();
    bit ok;
    wait_pos(HT - 1, 7, "wrap_wait", ok);
    if (!ok) return;
    vresync = 1'b1;
    step();
    vresync = 1'b0;
    checks++;
    if (bus.pix_x !== 10'd0 || bus.pix_y !== 9'd0) begin
      errors++;
      $display("FAIL wrap_restart: x=%0d y=%0d, want 0 0", bus.pix_x, bus.pix_y);
    end
    step(); step();
    checks++;
    if (field_start !== 1'b1) begin
      errors++;
      $display("FAIL wrap_field_start: got %b, want 1", field_start);
    end
    for (int i = 0; i < HT - 2; i++) step();
    checks++;
    if (bus.pix_y !== 9'd1) begin
      errors++;
      $display("FAIL wrap_no_pending: y=%0d, want 1", bus.pix_y);
    end
  endtask

  task automatic test_reset_mid_hsync();
    bit ok;
    wait_pos(210, 17, "midrst_wait", ok);
    if (!ok) return;
    checks++;
    if ({hsync_ext_n, vsync_ext_n, csync_ext_n} !== 3'b001) begin
      errors++;
      $display("FAIL midrst_pre: h/v/c=%b, want 001", {hsync_ext_n, vsync_ext_n, csync_ext_n});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hsync_ext_n, vsync_ext_n, csync_ext_n} !== 3'b111 || blank !== 1'b1 ||
        {ro, go, bo} !== 9'd0 || field_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: h/v/c=%b blank=%b rgb=%h fs=%b, want 111 1 000 0",
               {hsync_ext_n, vsync_ext_n, csync_ext_n}, blank, {ro, go, bo}, field_start);
    end
    checks++;
    if (bus.pix_x !== 10'd0 || bus.pix_y !== 9'd0) begin
      errors++;
      $display("FAIL midrst_counters: x=%0d y=%0d, want 0 0", bus.pix_x, bus.pix_y);
    end
    step(); step();
    #3 rst_n = 1'b1;
    step();
    checks++;
    if (bus.pix_x !== 10'd1 || bus.pix_y !== 9'd0 || hsync_ext_n !== 1'b1) begin
      errors++;
      $display("FAIL midrst_resume: x=%0d y=%0d hs=%b, want 1 0 1",
               bus.pix_x, bus.pix_y, hsync_ext_n);
    end
    step();
    checks++;
    if (field_start !== 1'b1) begin
      errors++;
      $display("FAIL midrst_field_start: got %b, want 1", field_start);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pix_req_latency();
    test_vresync();
    test_resync_at_wrap();
    test_reset_mid_hsync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
